// File: rtl/fmq_cmd_pkg.sv
// fmq_cmd_pkg
//   Shared types and helpers for the levitator 3-byte UART command master.
//   - fmq_op_e     : high-level command opcodes (6 and 7 are illegal)
//   - fmq_status_e : completion status codes
//   - fmq_state_e  : command master FSM states
//   - fixed first-byte constants for the parameterless commands
//   - fmq_pack_frame(): encodes op/addr/data into {byte0, byte1, byte2}
package fmq_cmd_pkg;

  typedef enum logic [2:0] {
    OP_SET_OFFSET    = 3'd0,
    OP_SET_DIVISOR   = 3'd1,
    OP_QUERY_OUTPUTS = 3'd2,
    OP_SET_DAC       = 3'd3,
    OP_RELOAD        = 3'd4,
    OP_QUERY_VERSION = 3'd5
  } fmq_op_e;

  typedef enum logic [1:0] {
    STS_OK             = 2'd0,
    STS_ECHO_MISMATCH  = 2'd1,
    STS_TIMEOUT        = 2'd2,
    STS_ILLEGAL_OP     = 2'd3
  } fmq_status_e;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_SEND       = 3'd1,
    S_WAIT_ECHO  = 3'd2,
    S_WAIT_REPLY = 3'd3,
    S_RESP       = 3'd4
  } fmq_state_e;

  localparam logic [7:0] FMQ_B0_QUERY_OUTPUTS = 8'hC0;
  localparam logic [7:0] FMQ_B0_SET_DAC       = 8'hE0;
  localparam logic [7:0] FMQ_B0_QUERY_VERSION = 8'hE8;
  localparam logic [7:0] FMQ_B0_RELOAD        = 8'hF0;

  function automatic logic fmq_op_legal(input logic [2:0] op);
    return (op <= 3'd5);
  endfunction

  function automatic logic fmq_op_is_query(input logic [2:0] op);
    return (op == OP_QUERY_OUTPUTS) || (op == OP_QUERY_VERSION);
  endfunction

  // Byte0 always carries bit 7 set, byte1/byte2 carry bit 7 clear.
  // Illegal ops encode as all-zero; they are never transmitted.
  function automatic logic [23:0] fmq_pack_frame(input logic [2:0]  op,
                                                 input logic [6:0]  addr,
                                                 input logic [18:0] data);
    logic [23:0] f;
    f = 24'h000000;
    case (op)
      OP_SET_OFFSET:    f = {1'b1, 2'b00, addr[6:2],
                             1'b0, addr[1:0], data[11:7],
                             1'b0, data[6:0]};
      OP_SET_DIVISOR:   f = {1'b1, 2'b01, data[18:14],
                             1'b0, data[13:7],
                             1'b0, data[6:0]};
      OP_QUERY_OUTPUTS: f = {FMQ_B0_QUERY_OUTPUTS, 8'h00, 8'h00};
      OP_SET_DAC:       f = {FMQ_B0_SET_DAC,
                             1'b0, 5'b00000, data[8:7],
                             1'b0, data[6:0]};
      OP_RELOAD:        f = {FMQ_B0_RELOAD, 8'h00, 8'h00};
      OP_QUERY_VERSION: f = {FMQ_B0_QUERY_VERSION, 8'h00, 8'h00};
      default:          f = 24'h000000;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/fmq_cmd_master_if.sv
// fmq_cmd_master_if
//   Bundles the command, UART tx/rx AXI-stream and response handshakes of
//   the command master.
//   - master : view of the command master itself
//   - slave  : view of the environment (sequencer + UART)
interface fmq_cmd_master_if;
  // command request
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [6:0]  cmd_addr;
  logic [18:0] cmd_data;
  // bytes to the UART transmitter
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  // bytes from the UART receiver
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  // completion
  logic        resp_valid;
  logic        resp_ready;
  logic [7:0]  resp_data;
  logic [1:0]  resp_status;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data,
    input  tx_ready, rx_data, rx_valid, resp_ready,
    output cmd_ready, tx_data, tx_valid, rx_ready,
    output resp_valid, resp_data, resp_status
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_data,
    output tx_ready, rx_data, rx_valid, resp_ready,
    input  cmd_ready, tx_data, tx_valid, rx_ready,
    input  resp_valid, resp_data, resp_status
  );
endinterface

// File: rtl/fmq_cmd_master.sv
// fmq_cmd_master
//   Host-side initiator for the 3-byte levitator UART command protocol.
//   Takes one command at a time, sends its frame byte by byte, waits for
//   each byte to be echoed before sending the next, and for queries
//   collects one extra reply byte. Aborts on echo mismatch or on TIMEOUT
//   clk cycles without a received byte.
// Ports
//   clk : system clock
//   rst : asynchronous active-low reset
//   bus : fmq_cmd_master_if.master (cmd / tx / rx / resp handshakes)
// Parameters
//   TIMEOUT : idle cycles in a wait state before aborting
//   CNT_W   : timeout counter width, 2**CNT_W > TIMEOUT
module fmq_cmd_master
  import fmq_cmd_pkg::*;
#(
  parameter int TIMEOUT = 100000,
  parameter int CNT_W   = 17
) (
  input  logic                 clk,
  input  logic                 rst,
  fmq_cmd_master_if.master     bus
);

  fmq_state_e        r_state;
  logic [2:0]        r_op;
  logic [23:0]       r_frame;
  logic [1:0]        r_idx;
  logic [CNT_W-1:0]  r_cnt;
  logic [7:0]        r_tx_data;
  logic              r_tx_valid;
  logic              r_rx_ready;
  logic              r_resp_valid;
  logic [7:0]        r_resp_data;
  logic [1:0]        r_resp_status;

  logic [23:0]       w_pack;
  logic [7:0]        w_sent_byte;
  logic [7:0]        w_next_byte;
  logic              w_timeout;

  assign w_pack = fmq_pack_frame(bus.cmd_op, bus.cmd_addr, bus.cmd_data);

  always_comb begin
    w_sent_byte = r_frame[7:0];
    case (r_idx)
      2'd0:    w_sent_byte = r_frame[23:16];
      2'd1:    w_sent_byte = r_frame[15:8];
      default: w_sent_byte = r_frame[7:0];
    endcase
  end

  assign w_next_byte = (r_idx == 2'd0) ? r_frame[15:8] : r_frame[7:0];

  // The counter holds the number of completed idle cycles in the wait
  // state; the cycle in which it would reach TIMEOUT is the abort cycle.
  // Checked before rx_valid so a byte in that same cycle loses.
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_op          <= 3'd0;
      r_frame       <= 24'h000000;
      r_idx         <= 2'd0;
      r_cnt         <= '0;
      r_tx_data     <= 8'h00;
      r_tx_valid    <= 1'b0;
      r_rx_ready    <= 1'b1;
      r_resp_valid  <= 1'b0;
      r_resp_data   <= 8'h00;
      r_resp_status <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // rx_ready stays high here so stray bytes are drained and dropped
          r_rx_ready <= 1'b1;
          if (bus.cmd_valid) begin
            r_op    <= bus.cmd_op;
            r_frame <= w_pack;
            r_idx   <= 2'd0;
            if (fmq_op_legal(bus.cmd_op)) begin
              r_state    <= S_SEND;
              r_tx_valid <= 1'b1;
              r_tx_data  <= w_pack[23:16];
              r_rx_ready <= 1'b0;
            end else begin
              r_state       <= S_RESP;
              r_resp_valid  <= 1'b1;
              r_resp_data   <= 8'h00;
              r_resp_status <= STS_ILLEGAL_OP;
              r_rx_ready    <= 1'b0;
            end
          end
        end

        S_SEND: begin
          if (bus.tx_ready) begin
            r_tx_valid <= 1'b0;
            r_rx_ready <= 1'b1;
            r_cnt      <= '0;
            r_state    <= S_WAIT_ECHO;
          end
        end

        S_WAIT_ECHO: begin
          if (w_timeout) begin
            r_state       <= S_RESP;
            r_resp_valid  <= 1'b1;
            r_resp_data   <= 8'h00;
            r_resp_status <= STS_TIMEOUT;
            r_rx_ready    <= 1'b0;
          end else if (bus.rx_valid) begin
            r_cnt <= '0;
            if (bus.rx_data != w_sent_byte) begin
              r_state       <= S_RESP;
              r_resp_valid  <= 1'b1;
              r_resp_data   <= 8'h00;
              r_resp_status <= STS_ECHO_MISMATCH;
              r_rx_ready    <= 1'b0;
            end else if (r_idx != 2'd2) begin
              r_idx      <= r_idx + 2'd1;
              r_state    <= S_SEND;
              r_tx_valid <= 1'b1;
              r_tx_data  <= w_next_byte;
              r_rx_ready <= 1'b0;
            end else if (fmq_op_is_query(r_op)) begin
              // rx_ready stays high to take the reply byte
              r_state <= S_WAIT_REPLY;
            end else begin
              r_state       <= S_RESP;
              r_resp_valid  <= 1'b1;
              r_resp_data   <= 8'h00;
              r_resp_status <= STS_OK;
              r_rx_ready    <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_WAIT_REPLY: begin
          if (w_timeout) begin
            r_state       <= S_RESP;
            r_resp_valid  <= 1'b1;
            r_resp_data   <= 8'h00;
            r_resp_status <= STS_TIMEOUT;
            r_rx_ready    <= 1'b0;
          end else if (bus.rx_valid) begin
            r_cnt         <= '0;
            r_state       <= S_RESP;
            r_resp_valid  <= 1'b1;
            r_resp_data   <= bus.rx_data;
            r_resp_status <= STS_OK;
            r_rx_ready    <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_RESP: begin
          if (bus.resp_ready) begin
            r_resp_valid  <= 1'b0;
            r_resp_data   <= 8'h00;
            r_resp_status <= 2'd0;
            r_rx_ready    <= 1'b1;
            r_idx         <= 2'd0;
            r_state       <= S_IDLE;
          end
        end

        default: begin
          r_state    <= S_IDLE;
          r_tx_valid <= 1'b0;
          r_rx_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.cmd_ready   = (r_state == S_IDLE);
  assign bus.tx_data     = r_tx_data;
  assign bus.tx_valid    = r_tx_valid;
  assign bus.rx_ready    = r_rx_ready;
  assign bus.resp_valid  = r_resp_valid;
  assign bus.resp_data   = r_resp_data;
  assign bus.resp_status = r_resp_status;

endmodule

// File: tb/tb_fmq_cmd_master.sv
// tb_fmq_cmd_master
//   Directed bench for fmq_cmd_master with an echoing target model driven
//   inline. TIMEOUT is shortened to 50 cycles.
module tb_fmq_cmd_master;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  fmq_cmd_master_if bus();

  fmq_cmd_master #(.TIMEOUT(50), .CNT_W(17)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a command for one cycle; legal ops must raise tx_valid next cycle.
  task automatic send_cmd(input logic [2:0] op, input logic [6:0] addr, input logic [18:0] data);
    check("cmd_ready_before", {31'd0, bus.cmd_ready}, 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = addr;
    bus.cmd_data  = data;
    step();
    bus.cmd_valid = 1'b0;
  endtask

  // Wait (bounded) for a tx byte and accept it.
  task automatic get_tx(input string tag, output logic [7:0] b);
    b = 8'h00;
    for (int i = 0; i < 20 && !bus.tx_valid; i++) step();
    if (!bus.tx_valid) begin
      check({tag, "_tx_wait"}, 32'd0, 32'd1);
    end else begin
      b = bus.tx_data;
      bus.tx_ready = 1'b1;
      step();
      bus.tx_ready = 1'b0;
    end
  endtask

  task automatic drive_rx(input logic [7:0] b);
    check("rx_ready_wait", {31'd0, bus.rx_ready}, 32'd1);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    step();
    bus.rx_valid = 1'b0;
  endtask

  task automatic check_resp(input string tag, input logic [1:0] sts, input logic [7:0] dat);
    check({tag, "_resp_valid"},  {31'd0, bus.resp_valid}, 32'd1);
    check({tag, "_resp_status"}, {30'd0, bus.resp_status}, {30'd0, sts});
    check({tag, "_resp_data"},   {24'd0, bus.resp_data}, {24'd0, dat});
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
    check({tag, "_back_idle"}, {31'd0, bus.cmd_ready}, 32'd1);
  endtask

  // Full write-style command against an echoing target.
  task automatic run_write(input string tag, input logic [2:0] op, input logic [6:0] addr,
                           input logic [18:0] data, input logic [23:0] exp_frame);
    logic [7:0] b;
    logic [7:0] exp_b;
    send_cmd(op, addr, data);
    check({tag, "_tx_valid_n1"}, {31'd0, bus.tx_valid}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      exp_b = (k == 0) ? exp_frame[23:16] : (k == 1) ? exp_frame[15:8] : exp_frame[7:0];
      get_tx(tag, b);
      check($sformatf("%s_byte%0d", tag, k), {24'd0, b}, {24'd0, exp_b});
      drive_rx(b);
      if (k < 2) check($sformatf("%s_next_tx%0d", tag, k), {31'd0, bus.tx_valid}, 32'd1);
    end
    check_resp(tag, 2'd0, 8'h00);
  endtask

  initial begin
    logic [7:0] b;
    int         n;
    logic       seen;
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = 3'd0;
    bus.cmd_addr   = 7'd0;
    bus.cmd_data   = 19'd0;
    bus.tx_ready   = 1'b0;
    bus.rx_data    = 8'h00;
    bus.rx_valid   = 1'b0;
    bus.resp_ready = 1'b0;
    step();
    step();

    // reset values
    check("rst_cmd_ready",   {31'd0, bus.cmd_ready}, 32'd1);
    check("rst_rx_ready",    {31'd0, bus.rx_ready}, 32'd1);
    check("rst_tx_valid",    {31'd0, bus.tx_valid}, 32'd0);
    check("rst_tx_data",     {24'd0, bus.tx_data}, 32'd0);
    check("rst_resp_valid",  {31'd0, bus.resp_valid}, 32'd0);
    check("rst_resp_data",   {24'd0, bus.resp_data}, 32'd0);
    check("rst_resp_status", {30'd0, bus.resp_status}, 32'd0);
    rst = 1'b1;
    step();

    // SET_OFFSET addr=87 data=0x805 -> 95 70 05
    run_write("offset", 3'd0, 7'd87, 19'h00805, 24'h957005);
    // SET_DIVISOR 100 -> A0 00 64
    run_write("divisor", 3'd1, 7'd0, 19'd100, 24'hA00064);
    // SET_DAC 256 -> E0 02 00
    run_write("dac", 3'd3, 7'd0, 19'd256, 24'hE00200);

    // cmd_valid while busy is ignored: poke an illegal op during WAIT_ECHO
    send_cmd(3'd4, 7'd0, 19'd0);
    get_tx("busy", b);
    check("busy_byte0", {24'd0, b}, 32'hF0);
    check("busy_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'd6;
    step();
    bus.cmd_valid = 1'b0;
    drive_rx(b);
    get_tx("busy", b);
    check("busy_byte1", {24'd0, b}, 32'h00);
    drive_rx(b);
    get_tx("busy", b);
    check("busy_byte2", {24'd0, b}, 32'h00);
    drive_rx(b);
    check_resp("busy", 2'd0, 8'h00);

    // QUERY_VERSION with reply 0x07
    send_cmd(3'd5, 7'd0, 19'd0);
    get_tx("ver", b);
    check("ver_byte0", {24'd0, b}, 32'hE8);
    drive_rx(b);
    get_tx("ver", b);
    check("ver_byte1", {24'd0, b}, 32'h00);
    drive_rx(b);
    get_tx("ver", b);
    check("ver_byte2", {24'd0, b}, 32'h00);
    drive_rx(b);
    check("ver_wait_reply", {31'd0, bus.resp_valid}, 32'd0);
    drive_rx(8'h07);
    check_resp("ver", 2'd0, 8'h07);

    // QUERY_OUTPUTS with a wrong echo
    send_cmd(3'd2, 7'd0, 19'd0);
    get_tx("qout", b);
    check("qout_byte0", {24'd0, b}, 32'hC0);
    drive_rx(8'h94);
    check_resp("qout", 2'd1, 8'h00);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.tx_valid) seen = 1'b1;
      step();
    end
    check("qout_no_more_tx", {31'd0, seen}, 32'd0);

    // RELOAD with no echo: 50 idle cycles in WAIT_ECHO then RESP
    send_cmd(3'd4, 7'd0, 19'd0);
    get_tx("tmo", b);
    check("tmo_byte0", {24'd0, b}, 32'hF0);
    n = 0;
    while (!bus.resp_valid && n < 200) begin
      step();
      n++;
    end
    check("tmo_cycles", n, 32'd50);
    check_resp("tmo", 2'd2, 8'h00);

    // illegal op 6: response next cycle, no tx
    send_cmd(3'd6, 7'd0, 19'd0);
    check("ill_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
    check_resp("ill", 2'd3, 8'h00);

    // reset while in SEND drops tx_valid without a clock edge
    send_cmd(3'd1, 7'd0, 19'd100);
    check("rsend_tx_valid_pre", {31'd0, bus.tx_valid}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("rsend_tx_valid_async", {31'd0, bus.tx_valid}, 32'd0);
    step();
    rst = 1'b1;
    step();

    // reset while in WAIT_ECHO
    send_cmd(3'd1, 7'd0, 19'd100);
    get_tx("recho", b);
    check("recho_byte0", {24'd0, b}, 32'hA0);
    rst = 1'b0;
    #1;
    check("recho_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check("recho_rx_ready",  {31'd0, bus.rx_ready}, 32'd1);
    check("recho_tx_valid",  {31'd0, bus.tx_valid}, 32'd0);
    check("recho_tx_data",   {24'd0, bus.tx_data}, 32'd0);
    check("recho_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    step();
    rst = 1'b1;
    step();
    run_write("post_rst", 3'd0, 7'd87, 19'h00805, 24'h957005);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
